// File: rtl/reqgnt_responder.sv
// reqgnt_responder
// Grant-side responder for a req/gnt handshake. Every accepted request is
// timestamped into a small circular buffer and granted exactly once, in FIFO
// order, between MIN_LAT and MAX_LAT cycles after it was raised. srv_ready
// allows an early grant; reaching the MAX_LAT deadline forces one.
module reqgnt_responder #(
    parameter int DEPTH   = 8,
    parameter int MIN_LAT = 2,
    parameter int MAX_LAT = 8,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req,
    input  logic          i_srv_ready,
    output logic          o_gnt,
    output logic          o_gnt_forced,
    output logic [CW-1:0] o_outstanding,
    output logic          o_full,
    output logic          o_err_drop
);

    // Timestamp width: one bit more than needed for MAX_LAT, so the modular
    // age of the head is always exact.
    localparam int TW = $clog2(MAX_LAT + 1) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [TW-1:0] FORCE_AGE = TW'(MAX_LAT - 1);
    localparam logic [TW-1:0] EARLY_AGE = TW'(MIN_LAT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

    // Wrapping pointer increment for a buffer whose depth need not be 2^n.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == LAST_PTR) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    // Age of a stored stamp relative to the free-running counter (mod 2^TW).
    function automatic logic [TW-1:0] age_of(input logic [TW-1:0] now,
                                             input logic [TW-1:0] stamp);
        return now - stamp;
    endfunction

    logic [TW-1:0] r_now;
    logic [TW-1:0] r_stamp [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_gnt;
    logic          r_gnt_forced;
    logic          r_err_drop;
    logic [CW-1:0] r_outstanding;

    logic [TW-1:0] w_head_age;
    logic          w_force;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_next;
    logic [CW:0]   w_out_sum;
    logic [CW-1:0] w_out_next;

    // Grant decision on the current head, accept/drop of the incoming request,
    // and the next values of the occupancy count and reported outstanding.
    always_comb begin
        w_head_age   = age_of(r_now, r_stamp[r_rd_ptr]);
        w_force      = 1'b0;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        w_count_next = r_count;
        w_out_sum    = {(CW+1){1'b0}};
        w_out_next   = {CW{1'b0}};

        if (r_count != {CW{1'b0}}) begin
            if (w_head_age == FORCE_AGE) begin
                w_force = 1'b1;
                w_pop   = 1'b1;
            end else if ((w_head_age >= EARLY_AGE) && i_srv_ready) begin
                w_pop   = 1'b1;
            end else begin
                w_pop   = 1'b0;
            end
        end else begin
            w_pop = 1'b0;
        end

        // A full buffer still takes a request when the head leaves at this edge.
        if (i_req && ((r_count < DEPTH_C) || w_pop)) begin
            w_push = 1'b1;
        end else begin
            w_drop = i_req;
        end

        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase

        // The request being granted next cycle is still reported as outstanding
        // during its grant cycle. A refill of a full buffer in the same edge
        // would overshoot, so the report is capped at DEPTH.
        w_out_sum = {1'b0, w_count_next} + {{CW{1'b0}}, w_pop};
        if (w_out_sum > {1'b0, DEPTH_C}) begin
            w_out_next = DEPTH_C;
        end else begin
            w_out_next = w_out_sum[CW-1:0];
        end
    end

    // Buffer, pointers, counters and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_now         <= {TW{1'b0}};
            r_wr_ptr      <= {PW{1'b0}};
            r_rd_ptr      <= {PW{1'b0}};
            r_count       <= {CW{1'b0}};
            r_gnt         <= 1'b0;
            r_gnt_forced  <= 1'b0;
            r_err_drop    <= 1'b0;
            r_outstanding <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_stamp[i] <= {TW{1'b0}};
            end
        end else begin
            r_now         <= r_now + TW'(1);
            r_count       <= w_count_next;
            r_gnt         <= w_pop;
            r_gnt_forced  <= w_force;
            r_err_drop    <= w_drop;
            r_outstanding <= w_out_next;
            if (w_push) begin
                r_stamp[r_wr_ptr] <= r_now;
                r_wr_ptr          <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
        end
    end

    assign o_gnt         = r_gnt;
    assign o_gnt_forced  = r_gnt_forced;
    assign o_err_drop    = r_err_drop;
    assign o_outstanding = r_outstanding;
    assign o_full        = (r_outstanding == DEPTH_C);

endmodule

// File: tb/tb_reqgnt_responder.sv
// Bench for reqgnt_responder: a default 8-deep instance and a 4-deep instance
// share the same directed stimulus. A queue-based model of request arrival
// cycles predicts every output each cycle; literal expectations pin the
// cycle-exact behaviour of the directed scenarios.
module tb_reqgnt_responder;

    localparam int MIN_LAT = 2;
    localparam int MAX_LAT = 8;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       srv;

    logic       g8, f8, full8, d8;
    logic [3:0] out8;
    logic       g4, f4, full4, d4;
    logic [2:0] out4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int q8[$];
    int q4[$];
    int exp_gnt[2];
    int exp_forced[2];
    int exp_out[2];
    int exp_drop[2];

    reqgnt_responder dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_srv_ready(srv),
        .o_gnt(g8), .o_gnt_forced(f8), .o_outstanding(out8),
        .o_full(full8), .o_err_drop(d8)
    );

    reqgnt_responder #(.DEPTH(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_srv_ready(srv),
        .o_gnt(g4), .o_gnt_forced(f4), .o_outstanding(out4),
        .o_full(full4), .o_err_drop(d4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // Model: the pending list holds arrival cycles. At the end of cycle 'cyc'
    // the oldest request is granted in cycle cyc+1 if that is exactly MAX_LAT
    // after its arrival (forced), or at least MIN_LAT after it with srv high.
    task automatic model_edge(input int inst);
        int q[$];
        int d;
        int pop;
        int frc;
        int acc;
        int k;
        int o;
        if (inst == 0) begin q = q8; d = 8; end
        else begin q = q4; d = 4; end
        pop = 0; frc = 0; acc = 0;
        if (rst_n == 1'b0) begin
            q.delete();
        end else begin
            if (q.size() > 0) begin
                k = cyc + 1 - q[0];
                if (k == MAX_LAT) begin pop = 1; frc = 1; end
                else if (k >= MIN_LAT && srv == 1'b1) pop = 1;
            end
            acc = (req == 1'b1 && (q.size() < d || pop == 1)) ? 1 : 0;
            if (pop == 1) void'(q.pop_front());
            if (acc == 1) q.push_back(cyc);
        end
        o = q.size() + pop;
        if (o > d) o = d;
        exp_gnt[inst]    = pop;
        exp_forced[inst] = frc;
        exp_out[inst]    = o;
        exp_drop[inst]   = (rst_n == 1'b1 && req == 1'b1 && acc == 0) ? 1 : 0;
        if (inst == 0) q8 = q; else q4 = q;
    endtask

    task automatic model_reset();
        q8.delete();
        q4.delete();
        for (int i = 0; i < 2; i++) begin
            exp_gnt[i] = 0; exp_forced[i] = 0; exp_out[i] = 0; exp_drop[i] = 0;
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    task automatic compare_all();
        chk("gnt8",     int'(g8),    exp_gnt[0]);
        chk("forced8",  int'(f8),    exp_forced[0]);
        chk("out8",     int'(out8),  exp_out[0]);
        chk("full8",    int'(full8), (exp_out[0] == 8) ? 1 : 0);
        chk("drop8",    int'(d8),    exp_drop[0]);
        chk("gnt4",     int'(g4),    exp_gnt[1]);
        chk("forced4",  int'(f4),    exp_forced[1]);
        chk("out4",     int'(out4),  exp_out[1]);
        chk("full4",    int'(full4), (exp_out[1] == 4) ? 1 : 0);
        chk("drop4",    int'(d4),    exp_drop[1]);
    endtask

    // One clock: model the edge that ends cycle 'cyc', drive the next cycle's
    // inputs shortly after the edge, then compare on the falling edge.
    task automatic cycle_step(input logic rq, input logic sr, input logic rn);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        cyc++;
        #1;
        req   = rq;
        srv   = sr;
        rst_n = rn;
        if (rn == 1'b0) model_reset();
        @(negedge clk);
        compare_all();
    endtask

    // Hand-computed expectations for the directed scenarios.
    task automatic pin_checks(input int id);
        case (id)
            1: begin
                if (cyc == 11) begin chk("s1_g11", int'(g8), 0); chk("s1_o11", int'(out8), 1); end
                if (cyc == 12) begin chk("s1_g12", int'(g8), 1); chk("s1_f12", int'(f8), 0);
                                     chk("s1_o12", int'(out8), 1); end
                if (cyc == 13) begin chk("s1_g13", int'(g8), 0); chk("s1_o13", int'(out8), 0); end
            end
            2: begin
                if (cyc == 17) chk("s2_g17", int'(g8), 0);
                if (cyc == 18) begin chk("s2_g18", int'(g8), 1); chk("s2_f18", int'(f8), 1); end
                if (cyc == 19) chk("s2_g19", int'(g8), 0);
            end
            3: begin
                chk("s3_outmax", (out8 <= 4'd2) ? 1 : 0, 1);
                if (cyc == 12) chk("s3_g12", int'(g8), 1);
                if (cyc == 19) chk("s3_g19", int'(g8), 1);
                if (cyc == 20) chk("s3_g20", int'(g8), 0);
            end
            4: begin
                chk("s4_nodrop", int'(d8), 0);
                if (cyc == 17) chk("s4_full17", int'(full8), 0);
                if (cyc == 18) begin chk("s4_full18", int'(full8), 1); chk("s4_o18", int'(out8), 8);
                                     chk("s4_f18", int'(f8), 1); end
                if (cyc == 33) begin chk("s4_g33", int'(g8), 1); chk("s4_f33", int'(f8), 1); end
                if (cyc == 34) chk("s4_g34", int'(g8), 0);
            end
            5: begin
                if (cyc == 14) chk("s5_d14", int'(d4), 0);
                if (cyc == 15) chk("s5_d15", int'(d4), 1);
                if (cyc == 16) chk("s5_d16", int'(d4), 1);
                if (cyc == 17) chk("s5_d17", int'(d4), 0);
                if (cyc == 18) begin chk("s5_g18", int'(g4), 1); chk("s5_f18", int'(f4), 1); end
                if (cyc == 21) begin chk("s5_g21", int'(g4), 1); chk("s5_f21", int'(f4), 1); end
                if (cyc == 22) chk("s5_g22", int'(g4), 0);
            end
            6: begin
                if (cyc == 12) chk("s6_o12", int'(out8), 2);
                if (cyc == 13) begin chk("s6_g13", int'(g8), 0); chk("s6_o13", int'(out8), 0); end
                if (cyc > 13) chk("s6_nognt", int'(g8 | g4), 0);
            end
            default: ;
        endcase
    endtask

    // Reset, then run cycles 1..40 with req high from rq_first to rq_last and
    // reset optionally reasserted for cycles [rst_at, rst_at+rst_len).
    task automatic run_scn(input int id, input int rq_first, input int rq_last,
                           input logic sr, input int rst_at, input int rst_len);
        logic rq;
        logic rn;
        cyc = -3;
        cycle_step(1'b0, 1'b0, 1'b0);
        cycle_step(1'b0, 1'b0, 1'b0);
        cycle_step(1'b0, sr, 1'b1);
        chk("reset_out8", int'(out8), 0);
        chk("reset_gnt8", int'(g8), 0);
        for (int c = 1; c <= 40; c++) begin
            rq = (c >= rq_first && c <= rq_last) ? 1'b1 : 1'b0;
            rn = (c >= rst_at && c < rst_at + rst_len) ? 1'b0 : 1'b1;
            cycle_step(rq, sr, rn);
            pin_checks(id);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        srv   = 1'b0;
        model_reset();
        run_scn(1, 10, 10, 1'b1, 100, 0);
        run_scn(2, 10, 10, 1'b0, 100, 0);
        run_scn(3, 10, 17, 1'b1, 100, 0);
        run_scn(4, 10, 25, 1'b0, 100, 0);
        run_scn(5, 10, 15, 1'b0, 100, 0);
        run_scn(6, 10, 11, 1'b0, 13, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
